// File: rtl/coh_bus_ctrl.sv
// coh_bus_ctrl: N-way snooping coherence controller and round-robin RAM arbiter
module coh_bus_ctrl #(
  parameter int CPUS = 2,
  parameter int AW = 32
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS*AW-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [CPUS*AW-1:0]  iload,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [CPUS*AW-1:0]  daddr,
  input  logic [CPUS*AW-1:0]  dstore,
  output logic [CPUS-1:0]     dwait,
  output logic [CPUS*AW-1:0]  dload,
  input  logic [CPUS-1:0]     cctrans,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [CPUS*AW-1:0]  ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [AW-1:0]       ramstore,
  input  logic [AW-1:0]       ramload,
  input  logic [1:0]          ramstate
);
  localparam int IW = CPUS > 1 ? $clog2(CPUS) : 1;
  localparam logic [1:0] ACCESS = 2'b10;
  typedef enum logic [1:0] {IDLE, SNOOP, C2C, RAM_XFER} state_t;
  state_t state, state_n;
  logic [IW-1:0] req, sup, cptr, wptr, iptr;
  logic [IW-1:0] req_n, sup_n, cptr_n, wptr_n, iptr_n;
  logic [IW-1:0] cg, wg, ig, dirty;
  logic has_dirty, acc;
  function automatic logic [IW-1:0] pick(input logic [CPUS-1:0] v, input logic [IW-1:0] p);
    logic [IW-1:0] r;
    logic [CPUS-1:0] s;
    r = p;
    for (int k = CPUS - 1; k >= 0; k--) begin
      s = v >> ((int'(p) + k) % CPUS);
      if (s[0]) r = IW'((int'(p) + k) % CPUS);
    end
    return r;
  endfunction
  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return IW'((int'(g) + 1) % CPUS);
  endfunction
  assign acc = ramstate == ACCESS;
  assign cg = pick(cctrans, cptr);
  assign wg = pick(dWEN, wptr);
  assign ig = pick(iREN, iptr);
  always_comb begin
    has_dirty = 1'b0;
    dirty = '0;
    for (int j = CPUS - 1; j >= 0; j--)
      if (j != int'(req) && ccwrite[j]) begin
        has_dirty = 1'b1;
        dirty = IW'(j);
      end
  end
  always_comb begin
    state_n = state;
    req_n = req;
    sup_n = sup;
    cptr_n = cptr;
    wptr_n = wptr;
    iptr_n = iptr;
    iwait = '1;
    dwait = '1;
    ccwait = '0;
    ccinv = '0;
    ccsnoopaddr = '0;
    iload = '0;
    dload = '0;
    ramREN = 1'b0;
    ramWEN = 1'b0;
    ramaddr = '0;
    ramstore = '0;
    if (state == IDLE) begin
      if (|cctrans) begin
        ccwait = ~(CPUS'(1) << cg);
        req_n = cg;
        state_n = SNOOP;
      end else if (|dWEN) begin
        ramWEN = 1'b1;
        ramaddr = daddr[int'(wg)*AW +: AW];
        ramstore = dstore[int'(wg)*AW +: AW];
        dwait[wg] = !acc;
        wptr_n = acc ? nxt(wg) : wptr;
      end else if (|iREN) begin
        ramREN = 1'b1;
        ramaddr = iaddr[int'(ig)*AW +: AW];
        iwait[ig] = !acc;
        iload[int'(ig)*AW +: AW] = acc ? ramload : '0;
        iptr_n = acc ? nxt(ig) : iptr;
      end
    end else begin
      // every non-requester keeps seeing the snoop for the whole transaction
      for (int j = 0; j < CPUS; j++)
        if (j != int'(req)) begin
          ccsnoopaddr[j*AW +: AW] = daddr[int'(req)*AW +: AW];
          ccwait[j] = cctrans[req];
          ccinv[j] = ccwrite[req];
        end
      if (state == SNOOP) begin
        state_n = !cctrans[req] ? IDLE : has_dirty ? C2C : RAM_XFER;
        sup_n = (cctrans[req] && has_dirty) ? dirty : sup;
      end else if (state == C2C) begin
        ramWEN = dWEN[sup];
        ramaddr = daddr[int'(req)*AW +: AW];
        ramstore = dstore[int'(sup)*AW +: AW];
        dload[int'(req)*AW +: AW] = dstore[int'(sup)*AW +: AW];
        dwait[req] = !acc;
        dwait[sup] = !acc;
      end else begin
        ramREN = dREN[req];
        ramWEN = dWEN[req];
        ramaddr = daddr[int'(req)*AW +: AW];
        ramstore = dstore[int'(req)*AW +: AW];
        dload[int'(req)*AW +: AW] = ramload;
        dwait[req] = !acc;
      end
      if (state != SNOOP && !cctrans[req]) begin
        state_n = IDLE;
        cptr_n = nxt(req);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      req <= '0;
      sup <= '0;
      cptr <= '0;
      wptr <= '0;
      iptr <= '0;
    end else begin
      state <= state_n;
      req <= req_n;
      sup <= sup_n;
      cptr <= cptr_n;
      wptr <= wptr_n;
      iptr <= iptr_n;
    end
  end
endmodule
